// File: rtl/fifo_pop_drain_ctrl_if.sv
// Downstream valid/ready word stream between the pop-side drain controller
// and its consumer.
//   m_data  : stream word, driven by the master
//   m_valid : word present, driven by the master
//   m_ready : consumer accepts the word this cycle, driven by the slave
interface fifo_pop_drain_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input  m_ready);
  modport slave  (input  m_data, input  m_valid, output m_ready);
endinterface

// File: rtl/fifo_pop_drain_ctrl.sv
// Pop-side controller for a FIFO_16K_BLK instance, entirely in the Pop_Clk
// domain. It watches POP_FLAG, issues POP strobes, captures DOUT after the
// FIFO read latency into a small skid buffer, and presents the words on a
// valid/ready stream so the consumer never sees FIFO timing.
//
// Ports
//   Pop_Clk        : clock, rising edge
//   Fifo_Pop_Flush : synchronous active-high reset; drops buffered and in-flight words
//   Drain_En       : 1 = may issue new POPs; 0 = stop popping, keep delivering
//   POP_FLAG       : FIFO status, 0 = empty, 1 = one word, other = two or more
//   DOUT           : FIFO read data, valid RD_LAT cycles after POP is sampled
//   POP            : pop strobe to the FIFO (registered)
//   strm           : downstream stream (m_data / m_valid / m_ready)
//   Pop_Count      : words delivered downstream, wraps modulo 2^CNT_W
//   Busy           : skid buffer non-empty or any pop in flight
module fifo_pop_drain_ctrl #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int SKID_D = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  Pop_Clk,
  input  logic                  Fifo_Pop_Flush,
  input  logic                  Drain_En,
  input  logic [3:0]            POP_FLAG,
  input  logic [DATA_W-1:0]     DOUT,
  output logic                  POP,
  fifo_pop_drain_ctrl_if.master strm,
  output logic [CNT_W-1:0]      Pop_Count,
  output logic                  Busy
);

  localparam int AW = $clog2(SKID_D);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [RD_LAT-1:0] infl_q, infl_d;
  logic              pop_q, pop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] skid_mem [SKID_D];

  logic [PW-1:0]     used;
  logic [PW:0]       occ;
  logic [PW:0]       occ_net;
  logic              empty;
  logic              full;
  logic              deq;
  logic              cap;
  logic              credit;
  logic              flag_ok;

  always_comb begin
    used  = wr_ptr_q - rd_ptr_q;
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    deq   = !empty && strm.m_ready;
    // The credit rule keeps the buffer from ever being full on arrival; the
    // full term only guards against a misuse of the parameters.
    cap   = infl_q[RD_LAT-1] && (!full || deq);

    // Committed words: buffered, in the read pipeline, and the POP on the wire now.
    occ = {1'b0, used} + (PW+1)'(pop_q);
    for (int i = 0; i < RD_LAT; i++) begin
      occ = occ + (PW+1)'(infl_q[i]);
    end
    occ_net = occ - (PW+1)'(deq);
    credit  = (occ_net < (PW+1)'(SKID_D));

    // POP_FLAG does not yet see the POP currently on the wire, so a flag of 1
    // while popping means that single word is already taken.
    flag_ok = (POP_FLAG >= 4'd2) || ((POP_FLAG == 4'd1) && !pop_q);
    pop_d   = Drain_En && credit && flag_ok;

    infl_d   = (infl_q << 1) | RD_LAT'(pop_q);
    wr_ptr_d = wr_ptr_q + PW'(cap);
    rd_ptr_d = rd_ptr_q + PW'(deq);
    cnt_d    = cnt_q + CNT_W'(deq);
  end

  always_ff @(posedge Pop_Clk) begin
    if (Fifo_Pop_Flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      infl_q   <= '0;
      pop_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      infl_q   <= infl_d;
      pop_q    <= pop_d;
      cnt_q    <= cnt_d;
    end
  end

  // Data storage needs no reset: m_data is forced to zero whenever the buffer is empty.
  always_ff @(posedge Pop_Clk) begin
    if (cap && !Fifo_Pop_Flush) begin
      skid_mem[wr_ptr_q[AW-1:0]] <= DOUT;
    end
  end

  always_comb begin
    POP          = pop_q;
    strm.m_valid = !empty;
    strm.m_data  = empty ? '0 : skid_mem[rd_ptr_q[AW-1:0]];
    Pop_Count    = cnt_q;
    Busy         = !empty || pop_q || (|infl_q);
  end

endmodule
